// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store stage:
//   - fun3 access-size encodings and the unsigned-load bit position
//   - LSU control state enumeration
//   - byte-lane mask generation, misalignment detection, size clamping and
//     offset alignment helpers. Every helper takes the lane count as an
//     argument so the same code serves 4-lane and 8-lane datapaths.
// ----------------------------------------------------------------------------
package lsu_pkg;

    // fun3[1:0] access size
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    // fun3[2] selects zero-extension on loads
    localparam int FUN3_UNSIGNED_BIT = 2;

    // Widest supported bus is 64 bits
    localparam int MAX_LANES = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    // Byte enables for an access of 'size' starting at lane 'offset'.
    // Lanes beyond the bus width are cut off by 'lanes'.
    function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0]  size,
                                                       input logic [2:0]  offset,
                                                       input int unsigned lanes);
        logic [15:0] span;
        logic [15:0] placed;
        logic [15:0] limit;
        case (size)
            SIZE_B:  span = 16'h0001;
            SIZE_H:  span = 16'h0003;
            SIZE_W:  span = 16'h000F;
            default: span = 16'h00FF;
        endcase
        placed = span << offset;
        limit  = (16'h0001 << lanes) - 16'h0001;
        return placed[MAX_LANES-1:0] & limit[MAX_LANES-1:0];
    endfunction

    // Natural-alignment check; a doubleword on a 4-lane bus counts as illegal.
    function automatic logic is_misaligned(input logic [1:0]  size,
                                           input logic [2:0]  offset,
                                           input int unsigned lanes);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = offset[0];
            SIZE_W:  bad = (offset[1:0] != 2'b00);
            default: bad = (lanes < 32'd8) || (offset != 3'b000);
        endcase
        return bad;
    endfunction

    // A doubleword on a 4-lane bus degrades to a word access.
    function automatic logic [1:0] clamp_size(input logic [1:0]  size,
                                              input int unsigned lanes);
        logic [1:0] eff;
        if ((size == SIZE_D) && (lanes < 32'd8)) begin
            eff = SIZE_W;
        end else begin
            eff = size;
        end
        return eff;
    endfunction

    // Round a lane offset down to a multiple of the access size.
    function automatic logic [2:0] align_offset(input logic [1:0] size,
                                                input logic [2:0] offset);
        logic [2:0] res;
        case (size)
            SIZE_B:  res = offset;
            SIZE_H:  res = {offset[2:1], 1'b0};
            SIZE_W:  res = {offset[2], 2'b00};
            default: res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_stage_lane_align.sv
// ----------------------------------------------------------------------------
// lsu_lane_align  (combinational)
// Request side : byte-lane mask and store data shifted into lane position.
// Response side: lane extraction at the latched offset plus sign/zero
//                extension of the loaded value.
// Ports:
//   req_size_i / req_offset_i   size and lane offset of the access being issued
//   store_src_i                 store operand, low bytes significant
//   mask_o / store_data_o       byte enables and lane-positioned store data
//   rsp_size_i / rsp_offset_i   size and offset latched for the outstanding load
//   rsp_unsigned_i              1 = zero-extend, 0 = sign-extend
//   load_raw_i / load_ext_o     raw bus word in, extended result out
// ----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic [1:0]                   req_size_i,
    input  logic [$clog2(DataWidth/8)-1:0] req_offset_i,
    input  logic [DataWidth-1:0]         store_src_i,
    output logic [DataWidth/8-1:0]       mask_o,
    output logic [DataWidth-1:0]         store_data_o,
    input  logic [1:0]                   rsp_size_i,
    input  logic [$clog2(DataWidth/8)-1:0] rsp_offset_i,
    input  logic                         rsp_unsigned_i,
    input  logic [DataWidth-1:0]         load_raw_i,
    output logic [DataWidth-1:0]         load_ext_o
);

    localparam int ByteLanes = DataWidth / 8;
    localparam int OffW      = $clog2(ByteLanes);
    localparam int MsbW      = $clog2(DataWidth);

    logic [2:0]           req_off3;
    logic [MAX_LANES-1:0] mask_full;
    logic [DataWidth-1:0] shifted;
    logic [MsbW-1:0]      msb_idx;
    logic                 fill;

    // Request side: lane mask and store data placed at the byte offset
    always_comb begin
        req_off3               = 3'b000;
        req_off3[OffW-1:0]     = req_offset_i;
        mask_full              = lane_mask(req_size_i, req_off3, ByteLanes);
        mask_o                 = mask_full[ByteLanes-1:0];
        store_data_o           = store_src_i << {req_offset_i, 3'b000};
    end

    // Response side: bring the addressed lanes down to bit 0 and extend above
    // the access MSB
    always_comb begin
        shifted = load_raw_i >> {rsp_offset_i, 3'b000};
        case (rsp_size_i)
            SIZE_B:  msb_idx = MsbW'(7);
            SIZE_H:  msb_idx = MsbW'(15);
            SIZE_W:  msb_idx = MsbW'(31);
            default: msb_idx = MsbW'(DataWidth - 1);
        endcase
        fill       = shifted[msb_idx] & ~rsp_unsigned_i;
        load_ext_o = shifted;
        for (int i = 0; i < DataWidth; i++) begin
            if (i > int'(msb_idx)) begin
                load_ext_o[i] = fill;
            end else begin
                load_ext_o[i] = shifted[i];
            end
        end
    end

endmodule

// File: rtl/lsu_stage.sv
// ----------------------------------------------------------------------------
// lsu_stage
// Load/store stage between execute and writeback. Issues one data-memory
// access per instruction through a request/ready + data_valid handshake and
// stalls the pipeline until the access completes.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned or illegal accesses pulse misalign_o and never
//               reach memory
//   undefined - misalign_o stays 0; the access is aligned down to its size
//               (a doubleword on a 32-bit bus is issued as a word)
//
// Ports (DataWidth = 32 or 64, ByteLanes = DataWidth/8):
//   clk_i, rst_i            clock, synchronous active-high reset
//   valid_i, load_i, store_i instruction qualifiers (load+store = store)
//   fun3_i                  [1:0] size, [2] unsigned load
//   operand_b_i             store data
//   alu_out_address_i       effective byte address
//   mem_ready_i             memory accepts the request this cycle
//   data_valid_i            load response valid (only honoured while waiting)
//   wrap_load_in_i          raw load response word
//   request_o, we_re_o      request valid, write(1)/read(0)
//   mask_o                  byte-lane enables
//   mem_addr_o              lane-aligned address
//   store_data_out_o        lane-positioned store data
//   wrap_load_out_o         extended load result, held until the next load
//   load_done_o             one-cycle completion pulse
//   stall_o                 hold the upstream pipeline
//   misalign_o              one-cycle trap pulse
// ----------------------------------------------------------------------------
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    input  logic                   load_i,
    input  logic                   store_i,
    input  logic [2:0]             fun3_i,
    input  logic [DataWidth-1:0]   operand_b_i,
    input  logic [DataWidth-1:0]   alu_out_address_i,
    input  logic                   mem_ready_i,
    input  logic                   data_valid_i,
    input  logic [DataWidth-1:0]   wrap_load_in_i,
    output logic                   request_o,
    output logic                   we_re_o,
    output logic [DataWidth/8-1:0] mask_o,
    output logic [DataWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   store_data_out_o,
    output logic [DataWidth-1:0]   wrap_load_out_o,
    output logic                   load_done_o,
    output logic                   stall_o,
    output logic                   misalign_o
);

    localparam int ByteLanes = DataWidth / 8;
    localparam int OffW      = $clog2(ByteLanes);

    // Registered state and outputs
    lsu_state_e            state_q;
    logic                  request_q;
    logic                  we_re_q;
    logic [ByteLanes-1:0]  mask_q;
    logic [DataWidth-1:0]  mem_addr_q;
    logic [DataWidth-1:0]  store_data_q;
    logic [DataWidth-1:0]  wrap_load_q;
    logic                  load_done_q;
    logic                  misalign_q;
    logic [1:0]            size_q;
    logic [OffW-1:0]       offset_q;
    logic                  unsigned_q;

    // Issue-side decode
    logic                  start;
    logic                  trap;
    logic [2:0]            off_raw3;
    logic [1:0]            eff_size;
    logic [2:0]            eff_off3;
    logic [OffW-1:0]       eff_off;
    logic [DataWidth-1:0]  addr_lane;
    logic [ByteLanes-1:0]  mask_s;
    logic [DataWidth-1:0]  store_shift_s;
    logic [DataWidth-1:0]  load_ext_s;

    // Decode the incoming instruction: start, trap, effective size and offset
    always_comb begin
        start                  = valid_i & (load_i | store_i);
        off_raw3               = 3'b000;
        off_raw3[OffW-1:0]     = alu_out_address_i[OffW-1:0];
        addr_lane              = alu_out_address_i;
        addr_lane[OffW-1:0]    = {OffW{1'b0}};
`ifdef LSU_MISALIGN_TRAP_EN
        trap                   = is_misaligned(fun3_i[1:0], off_raw3, ByteLanes);
        eff_size               = fun3_i[1:0];
`else
        trap                   = 1'b0;
        eff_size               = clamp_size(fun3_i[1:0], ByteLanes);
`endif
        // Non-trapping path always sees a size-aligned offset
        eff_off3               = align_offset(eff_size, off_raw3);
        eff_off                = eff_off3[OffW-1:0];
    end

    lsu_lane_align #(
        .DataWidth (DataWidth)
    ) u_lane_align (
        .req_size_i     (eff_size),
        .req_offset_i   (eff_off),
        .store_src_i    (operand_b_i),
        .mask_o         (mask_s),
        .store_data_o   (store_shift_s),
        .rsp_size_i     (size_q),
        .rsp_offset_i   (offset_q),
        .rsp_unsigned_i (unsigned_q),
        .load_raw_i     (wrap_load_in_i),
        .load_ext_o     (load_ext_s)
    );

    // Control FSM with registered handshake and completion outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            request_q    <= 1'b0;
            we_re_q      <= 1'b0;
            mask_q       <= {ByteLanes{1'b0}};
            mem_addr_q   <= {DataWidth{1'b0}};
            store_data_q <= {DataWidth{1'b0}};
            wrap_load_q  <= {DataWidth{1'b0}};
            load_done_q  <= 1'b0;
            misalign_q   <= 1'b0;
            size_q       <= 2'b00;
            offset_q     <= {OffW{1'b0}};
            unsigned_q   <= 1'b0;
        end else begin
            // Completion and trap flags are single-cycle pulses
            load_done_q <= 1'b0;
            misalign_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        we_re_q      <= store_i;
                        mask_q       <= mask_s;
                        mem_addr_q   <= addr_lane;
                        store_data_q <= store_shift_s;
                        size_q       <= eff_size;
                        offset_q     <= eff_off;
                        unsigned_q   <= fun3_i[FUN3_UNSIGNED_BIT];
                        if (trap) begin
                            misalign_q <= 1'b1;
                            state_q    <= ST_DONE;
                        end else begin
                            request_q  <= 1'b1;
                            state_q    <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // Request fields stay frozen until memory accepts
                    if (mem_ready_i) begin
                        request_q <= 1'b0;
                        if (we_re_q) begin
                            load_done_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            state_q     <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (data_valid_i) begin
                        wrap_load_q <= load_ext_s;
                        load_done_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // One dead cycle so a held instruction is not reissued
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    request_q <= 1'b0;
                end
            endcase
        end
    end

    // Stall covers the accept cycle and every cycle the access is in flight
    assign stall_o          = ((state_q == ST_IDLE) & start)
                            | (state_q == ST_REQ)
                            | (state_q == ST_WAIT);

    assign request_o        = request_q;
    assign we_re_o          = we_re_q;
    assign mask_o           = mask_q;
    assign mem_addr_o       = mem_addr_q;
    assign store_data_out_o = store_data_q;
    assign wrap_load_out_o  = wrap_load_q;
    assign load_done_o      = load_done_q;
    assign misalign_o       = misalign_q;

endmodule

// File: tb/tb_lsu_stage.sv
// ----------------------------------------------------------------------------
// tb_lsu_stage
// Drives a 32-bit and a 64-bit lsu_stage in parallel with directed and random
// loads/stores. A reference model predicts each access from address
// arithmetic; predictions go into a per-instance queue that a monitor process
// consumes whenever the DUT raises request, load_done or misalign.
// ----------------------------------------------------------------------------
module tb_lsu_stage;

    typedef struct {
        bit          trap;
        bit          is_store;
        logic [7:0]  mask;
        logic [63:0] addr;
        logic [63:0] sdata;
        logic [63:0] ldata;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        bit          st;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] rd;
        int          rdy;
        int          dv;
    } dir_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    function automatic void chk(string name, int w, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (w=%0d) got=%h exp=%h t=%0t", name, w, got, exp, $time);
        end
    endfunction

    // Reference model: what a given access should look like on the bus
    function automatic exp_t model(int lanes, logic [2:0] f3, bit st,
                                   logic [63:0] addr, logic [63:0] opb, logic [63:0] rdata);
        exp_t        e;
        int          nb, boff, off;
        logic [63:0] wmask, keep, v;
        logic [15:0] mm;
        wmask = (lanes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        nb    = 1 << f3[1:0];
        boff  = int'(addr[2:0]) % lanes;
`ifdef LSU_MISALIGN_TRAP_EN
        e.trap = (nb > lanes) || ((boff % nb) != 0);
`else
        e.trap = 1'b0;
`endif
        if (nb > lanes) nb = lanes;
        off        = boff - (boff % nb);
        e.is_store = st;
        mm         = 16'(((1 << nb) - 1) << off);
        e.mask     = mm[7:0];
        e.addr     = (addr - 64'(boff)) & wmask;
        e.sdata    = (opb << (8 * off)) & wmask;
        keep       = (nb < 8) ? ((64'd1 << (8 * nb)) - 64'd1) : 64'hFFFF_FFFF_FFFF_FFFF;
        v          = ((rdata & wmask) >> (8 * off)) & keep;
        if (!f3[2] && v[8*nb-1]) v = v | ~keep;
        e.ldata    = v & wmask;
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_w
        localparam int W = (g == 0) ? 32 : 64;
        localparam int L = W / 8;

        logic         rst, valid, load, store, mem_ready, data_valid;
        logic [2:0]   fun3;
        logic [W-1:0] opb, addr, rdata;
        logic         request, we_re, load_done, stall, misalign;
        logic [L-1:0] mask;
        logic [W-1:0] mem_addr, sdata, wload;
        exp_t         q[$];
        logic [63:0]  last_load;

        lsu_stage #(.DataWidth(W)) u_dut (
            .clk_i             (clk),
            .rst_i             (rst),
            .valid_i           (valid),
            .load_i            (load),
            .store_i           (store),
            .fun3_i            (fun3),
            .operand_b_i       (opb),
            .alu_out_address_i (addr),
            .mem_ready_i       (mem_ready),
            .data_valid_i      (data_valid),
            .wrap_load_in_i    (rdata),
            .request_o         (request),
            .we_re_o           (we_re),
            .mask_o            (mask),
            .mem_addr_o        (mem_addr),
            .store_data_out_o  (sdata),
            .wrap_load_out_o   (wload),
            .load_done_o       (load_done),
            .stall_o           (stall),
            .misalign_o        (misalign)
        );

        // Monitor: compare every request cycle and every completion
        always @(negedge clk) begin
            if (!rst) begin
                if (request) begin
                    if (q.size() == 0 || q[0].trap) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_request (w=%0d) got=1 exp=0 t=%0t", W, $time);
                    end else begin
                        chk("we_re", W, 64'(we_re), 64'(q[0].is_store));
                        chk("mask", W, 64'(mask), 64'(q[0].mask[L-1:0]));
                        chk("mem_addr", W, 64'(mem_addr), q[0].addr);
                        chk("store_data", W, 64'(sdata), q[0].sdata);
                    end
                end
                if (load_done || misalign) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done (w=%0d) got=%0d%0d exp=00 t=%0t",
                                 W, load_done, misalign, $time);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("misalign", W, 64'(misalign), 64'(e.trap));
                        chk("load_done", W, 64'(load_done), 64'(!e.trap));
                        if (!e.trap && !e.is_store) begin
                            chk("load_data", W, 64'(wload), e.ldata);
                            last_load = e.ldata;
                        end else begin
                            chk("load_hold", W, 64'(wload), last_load);
                        end
                    end
                end
            end
        end

        // Stimulus: directed table then random accesses, then reset mid-load
        initial begin
            dir_t        dt[8];
            exp_t        e;
            logic [2:0]  f3;
            bit          st, ld, fin;
            logic [63:0] a, b, rd;
            int          rdy, dv, exp_lat, req_n, wait_n, gap, r;

            dt[0] = '{3'b010, 1'b1, 64'h100, 64'hDEADBEEF, 64'h0, 0, 0};
            dt[1] = '{3'b000, 1'b0, 64'h103, 64'h0, 64'h80000000, 0, 0};
            dt[2] = '{3'b100, 1'b0, 64'h103, 64'h0, 64'h80000000, 0, 0};
            dt[3] = '{3'b001, 1'b0, 64'h102, 64'h0, 64'h12348765ABCD0000, 3, 0};
            dt[4] = '{3'b010, 1'b0, 64'h101, 64'h0, 64'hCAFEF00D, 0, 1};
            dt[5] = '{3'b011, 1'b1, 64'h8, 64'h1122334455667788, 64'h0, 0, 0};
            dt[6] = '{3'b011, 1'b0, 64'h4, 64'h0, 64'h0123456789ABCDEF, 1, 2};
            dt[7] = '{3'b000, 1'b1, 64'h7, 64'hA5, 64'h0, 1, 0};

            rst = 1'b1; valid = 1'b0; load = 1'b0; store = 1'b0; fun3 = 3'b000;
            opb = '0; addr = '0; mem_ready = 1'b0; data_valid = 1'b1; rdata = '1;
            last_load = 64'h0;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            // Stale response right after reset must be ignored
            repeat (2) @(negedge clk);
            #1;
            chk("reset_ctrl", W, {60'h0, request, load_done, misalign, stall}, 64'h0);
            chk("reset_data", W, 64'(mem_addr) | 64'(sdata) | 64'(wload) | 64'(mask) | 64'(we_re), 64'h0);
            data_valid = 1'b0;
            @(negedge clk);

            for (int t = 0; t < 208; t++) begin
                if (t < 8) begin
                    f3 = dt[t].f3; st = dt[t].st; ld = !dt[t].st;
                    a = dt[t].a; b = dt[t].b; rd = dt[t].rd; rdy = dt[t].rdy; dv = dt[t].dv;
                end else begin
                    f3 = 3'($urandom);
                    r  = int'($urandom % 3);
                    st = (r != 0); ld = (r != 1);
                    a  = {$urandom, $urandom}; b = {$urandom, $urandom}; rd = {$urandom, $urandom};
                    rdy = int'($urandom % 3); dv = int'($urandom % 3);
                end
                e = model(L, f3, st, a, b, rd);
                q.push_back(e);
                exp_lat = e.trap ? 1 : (st ? 2 + rdy : 3 + rdy + dv);

                valid = 1'b1; load = ld; store = st; fun3 = f3;
                addr = a[W-1:0]; opb = b[W-1:0];
                mem_ready = 1'($urandom % 2); data_valid = 1'($urandom % 2);
                rdata = W'({$urandom, $urandom});
                #1 chk("stall_accept", W, 64'(stall), 64'h1);
                @(posedge clk);

                req_n = 0; wait_n = 0; fin = 1'b0;
                for (int c = 1; c <= 40 && !fin; c++) begin
                    @(negedge clk);
                    if (load_done || misalign) begin
                        fin = 1'b1;
                        chk("latency", W, 64'(c), 64'(exp_lat));
                        mem_ready = 1'b0; data_valid = 1'($urandom % 2);
                        #1 chk("stall_done", W, 64'(stall), 64'h0);
                    end else begin
                        mem_ready  = 1'b0;
                        data_valid = 1'($urandom % 2);
                        rdata      = W'({$urandom, $urandom});
                        if (request) begin
                            mem_ready = (req_n == rdy);
                            req_n++;
                        end else begin
                            data_valid = (wait_n == dv);
                            if (data_valid) rdata = rd[W-1:0];
                            wait_n++;
                        end
                        #1 chk("stall_busy", W, 64'(stall), 64'h1);
                    end
                end
                if (!fin) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout_txn (w=%0d) got=none exp=done t=%0t", W, $time);
                    rst = 1'b1;
                    @(negedge clk);
                    @(negedge clk);
                    rst = 1'b0;
                    q.delete();
                    last_load = 64'h0;
                end
                // Instruction stays held through DONE; it must not reissue
                @(negedge clk);
                gap = int'($urandom % 3);
                repeat (gap) begin
                    valid = 1'($urandom % 2); load = 1'b0; store = 1'b0;
                    data_valid = 1'($urandom % 2);
                    @(negedge clk);
                end
            end

            // Reset while waiting for load data
            valid = 1'b1; load = 1'b1; store = 1'b0; fun3 = 3'b010;
            addr = W'(64'h200); opb = '0; mem_ready = 1'b0; data_valid = 1'b0;
            q.push_back(model(L, 3'b010, 1'b0, 64'h200, 64'h0, 64'h0));
            @(negedge clk);
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0; valid = 1'b0; load = 1'b0; rst = 1'b1;
            @(negedge clk);
            rst = 1'b0; data_valid = 1'b1; rdata = W'({$urandom, $urandom});
            q.delete();
            last_load = 64'h0;
            @(negedge clk);
            #1;
            chk("rst_mid_ctrl", W, {60'h0, request, load_done, misalign, stall}, 64'h0);
            chk("rst_mid_data", W, 64'(mem_addr) | 64'(sdata) | 64'(wload) | 64'(mask) | 64'(we_re), 64'h0);
            data_valid = 1'b0;
            repeat (3) @(negedge clk);
            chk("sb_empty", W, 64'(q.size()), 64'h0);
            done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && done_cnt < 2; i++) @(posedge clk);
        if (done_cnt < 2) begin
            checks++;
            errors++;
            $display("FAIL global_timeout got=%0d exp=2", done_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
# lsu_stage

Parametrised load/store stage for the core pipeline, sitting between execute and writeback. It drives the data-memory request/response handshake and generates byte-lane masks and lane-aligned store data. It also sign/zero-extends load data, detects misaligned accesses, and stalls the pipeline until each access completes. Data width is generalised to 32 or 64 bits: RV32I/RV64I byte, half, word and doubleword accesses.

## Interface
- DataWidth, 32, datapath/bus width; legal values 32 or 64
- ByteLanes, DataWidth/8, derived; mask width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- valid  in  1  instruction in stage is live
- load  in  1  instruction is a load
- store  in  1  instruction is a store
- fun3  in  3  instruction[14:12]; [1:0] size (B/H/W/D), [2] unsigned-load
- operand_b  in  DataWidth  store data (low bytes significant)
- alu_out_address  in  DataWidth  effective byte address
- mem_ready  in  1  memory accepts request this cycle
- data_valid  in  1  load response valid
- wrap_load_in  in  DataWidth  raw load response word
- request  out  1  memory request valid
- we_re  out  1  1 = write, 0 = read; meaningful only with request
- mask  out  ByteLanes  byte-lane enables
- mem_addr  out  DataWidth  lane-aligned address (low log2(ByteLanes) bits zero)
- store_data_out  out  DataWidth  store data shifted to lane position
- wrap_load_out  out  DataWidth  extended load result, registered
- load_done  out  1  one-cycle pulse: access complete, wrap_load_out valid for loads
- stall  out  1  hold upstream pipeline
- misalign  out  1  one-cycle pulse: access trapped, no memory request issued

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: start = valid & (load | store); load & store both high is treated as store. On start, latch address, fun3, offset, mask, shifted store data, and op.
  - Aligned access: go to REQ.
  - Misaligned access (with macro): go to DONE with misalign set.
- REQ: request=1, we_re=store, mask/mem_addr/store_data_out held stable until mem_ready.
  - mem_ready & store: go to DONE.
  - mem_ready & load: go to WAIT.
  - data_valid in REQ is ignored.
- WAIT: request=0. On data_valid, extract lanes at the latched offset, extend, register into wrap_load_out, and go to DONE.
- DONE: load_done=1 (0 if trapped), stall=0, return to IDLE unconditionally. Inputs are ignored for this cycle so a held instruction is not reissued.
- stall = start in IDLE, or state is REQ/WAIT.
- Size decode from fun3[1:0]:
  - 00: 1 lane at offset
  - 01: 2 lanes
  - 10: 4 lanes
  - 11: all 8 lanes (DataWidth=64 only; illegal at 32 and flagged as misaligned)
- Misaligned: half at odd offset, word at offset%4≠0, dword at offset≠0.
- Load extension: fun3[2]=0 sign-extends from the access MSB; fun3[2]=1 zero-extends.
- Store data: operand_b low bytes left-shifted by offset×8; bytes outside the mask are don't-care but are driven as the shifted value.
- data_valid outside WAIT is ignored, including stale responses after reset.

## Timing
- Reset values: request, we_re, load_done, misalign, stall-state = 0; mask=0; mem_addr, store_data_out, wrap_load_out = 0; state = IDLE.
- Reset mid-access: request drops at the next edge and no load_done is produced.
- Store latency: accept cycle N, request in N+1; with mem_ready in N+1, load_done in N+2. Minimum 3 cycles including DONE.
- Load latency: accept N, request N+1 with mem_ready, data_valid N+2, load_done/wrap_load_out in N+3.
- Each mem_ready wait cycle or data_valid wait cycle adds exactly one cycle.
- Misalign trap: accept N, misalign pulse and DONE in N+1. request never asserts.
- wrap_load_out holds its value until the next completed load.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned/illegal accesses pulse misalign and skip memory.
- Undefined: misalign is tied 0. The access proceeds with the address aligned down to the access size, and the mask is computed from the aligned offset.

## Structure
- Package lsu_pkg holds:
  - fun3 size/unsigned encodings
  - state enum (IDLE/REQ/WAIT/DONE)
  - mask-generation function parameterised by ByteLanes
- One sub-module, lsu_lane_align (combinational): store shift and mask on the request side, load lane extract and extension on the response side.

## Test plan
- SW 0xDEADBEEF to 0x100, mem_ready immediate -> mask=0xF, store_data_out=0xDEADBEEF, we_re=1, load_done 2 cycles after accept.
- LB from 0x103, wrap_load_in=0x80000000 -> mask=0x8, wrap_load_out=0xFFFFFF80; LBU -> 0x00000080.
- LH at 0x102, mem_ready delayed 3 cycles -> request held with stable mask=0xC, stall high throughout, load_done at accept+6.
- LW at 0x101 with macro -> misalign pulse at accept+1, request never high; without macro -> mem_addr=0x100, mask=0xF.
- DataWidth=64: SD to 0x8 -> mask=0xFF; LD at 0x4 -> misalign.
- rst asserted while in WAIT, data_valid next cycle -> no load_done, state IDLE, all outputs zero.
